// File: rtl/hypot_pkg.sv
// hypot_pkg: shared types and widths for the hypotenuse scheduler.
// Contents: hypot_state_t FSM encoding (ROUND exists only when HYPOT_ROUND_EN is defined),
// operand/result/accumulator/remainder widths and the square-root iteration count.
package hypot_pkg;

    localparam int XW         = 8;
    localparam int RW         = XW + 1;
    localparam int ACC_W      = 18;
    localparam int REM_W      = 11;
    localparam int SQRT_ITERS = 9;

    typedef enum logic [2:0] {
        IDLE,
        SQ_X,
        SQ_Y,
        SQRT,
`ifdef HYPOT_ROUND_EN
        ROUND,
`endif
        DONE
    } hypot_state_t;

endpackage

// File: rtl/hypot_isqrt_step.sv
// hypot_isqrt_step: one combinational restoring square-root iteration.
// Ports: rem_in/root_in  partial remainder and root before the step
//        bits            next two radicand bits, MSB pair first
//        rem_out/root_out partial remainder and root after the step
module hypot_isqrt_step import hypot_pkg::*; (
    input  logic [REM_W-1:0] rem_in,
    input  logic [RW-1:0]    root_in,
    input  logic [1:0]       bits,
    output logic [REM_W-1:0] rem_out,
    output logic [RW-1:0]    root_out
);

    // Two extra bits of headroom: the shifted-in candidate can exceed the
    // stored remainder range before the trial subtraction brings it back.
    logic [REM_W+1:0] cand;
    logic [REM_W+1:0] trial;
    logic             ge;

    assign cand     = {rem_in, bits};
    assign trial    = (REM_W+2)'({root_in, 2'b01});
    assign ge       = cand >= trial;
    assign rem_out  = REM_W'(ge ? cand - trial : cand);
    assign root_out = RW'({root_in, ge});

endmodule

// File: rtl/hypot_sched.sv
// hypot_sched: round-robin two-requester scheduler for a shared hypotenuse engine.
// Ports: clk, rst (sync, active-high), ena (global hold)
//        req_valid/req_x/req_y/req_ready  per-requester request handshake (2 lanes)
//        out_valid/out_ready/out_data/out_id  result handshake, data = isqrt(x^2+y^2)
//        busy  engine not idle
// Build option: define HYPOT_ROUND_EN for round-to-nearest results (one extra cycle);
// otherwise the result is the floor.
module hypot_sched import hypot_pkg::*; #(
    parameter int XW = hypot_pkg::XW,
    parameter int RW = XW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [1:0]      req_valid,
    input  logic [2*XW-1:0] req_x,
    input  logic [2*XW-1:0] req_y,
    output logic [1:0]      req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_data,
    output logic            out_id,
    output logic            busy
);

    hypot_state_t     state;
    logic             rr_ptr;
    logic [XW-1:0]    x, y;
    logic             id;
    logic [ACC_W-1:0] acc;
    logic [REM_W-1:0] rem, rem_n;
    logic [RW-1:0]    root, root_n;
    logic [3:0]       cnt;

    logic             g;
    logic             take;
    logic [XW-1:0]    mul_a;
    logic [2*XW-1:0]  prod;
    logic [4:0]       idx;

    // The pointed-to requester wins a tie; otherwise fall over to the other one.
    assign g         = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign take      = (state == IDLE) && ena && !rst && req_valid[g];
    assign req_ready = take ? 2'(2'b01 << g) : 2'b00;
    assign busy      = state != IDLE;

    // Single multiplier shared by both squaring steps.
    assign mul_a = (state == SQ_X) ? x : y;
    assign prod  = mul_a * mul_a;

    // Radicand bit pair for the current iteration, consumed MSB pair first.
    assign idx = {cnt, 1'b0};

    hypot_isqrt_step u_step (
        .rem_in   (rem),
        .root_in  (root),
        .bits     (acc[idx +: 2]),
        .rem_out  (rem_n),
        .root_out (root_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            x         <= '0;
            y         <= '0;
            id        <= 1'b0;
            acc       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: if (req_valid[g]) begin
                    x      <= g ? req_x[2*XW-1:XW] : req_x[XW-1:0];
                    y      <= g ? req_y[2*XW-1:XW] : req_y[XW-1:0];
                    id     <= g;
                    rr_ptr <= ~g;
                    state  <= SQ_X;
                end
                SQ_X: begin
                    acc   <= ACC_W'(prod);
                    state <= SQ_Y;
                end
                SQ_Y: begin
                    acc   <= acc + ACC_W'(prod);
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= 4'(SQRT_ITERS - 1);
                    state <= SQRT;
                end
                SQRT: begin
                    rem  <= rem_n;
                    root <= root_n;
                    cnt  <= cnt - 1'b1;
`ifdef HYPOT_ROUND_EN
                    if (cnt == 4'd0) state <= ROUND;
`else
                    if (cnt == 4'd0) state <= DONE;
`endif
                end
`ifdef HYPOT_ROUND_EN
                // rem > root is the integer form of s >= (root + 0.5)^2.
                ROUND: begin
                    if (rem > REM_W'(root)) root <= root + 1'b1;
                    state <= DONE;
                end
`endif
                // First DONE cycle loads the output registers; they then hold until accepted.
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= root;
                    out_id    <= id;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_sched.sv
// tb_hypot_sched: scoreboard bench for hypot_sched with directed vectors.
module tb_hypot_sched;

`ifdef HYPOT_ROUND_EN
    localparam int LAT   = 13;
    localparam int BIG_R = 361;
`else
    localparam int LAT   = 12;
    localparam int BIG_R = 360;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_data;
    logic        out_id;
    logic        busy;

    hypot_sched dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [8:0] data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   busy_low = 0;
    bit   inflight = 0;
    bit   pv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string n, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, a, e);
        end
    endfunction

    // Monitor: latency at first valid, data/id at handshake, busy continuity.
    always @(negedge clk) begin
        exp_t e;
        if (inflight && !busy) busy_low++;
        if (out_valid && !pv) begin
            if (sb.size() == 0) check("unexpected_valid", 1, 0);
            else check("latency", cyc - acc_cyc, sb[0].lat);
        end
        if (out_valid && out_ready && ena && !rst && sb.size() != 0) begin
            e = sb.pop_front();
            check("data", int'(out_data), int'(e.data));
            check("id", int'(out_id), int'(e.id));
            check("busy_thru", busy_low, 0);
            inflight = 0;
        end
        if (req_ready != 2'b00) begin
            acc_cyc  = cyc + 1;
            inflight = 1;
            busy_low = 0;
        end
        pv = out_valid;
    end

    task automatic issue(input int i, input int x, input int y, input int d, input int lat, input bit push);
        exp_t e;
        req_x[i*8 +: 8] = 8'(x);
        req_y[i*8 +: 8] = 8'(y);
        req_valid[i]    = 1'b1;
        if (push) begin
            e.id   = 1'(i);
            e.data = 9'(d);
            e.lat  = lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_acc(input int i, output int at, output int n);
        at = -1;
        n  = 0;
        for (int k = 0; k < 100 && at < 0; k++) begin
            @(negedge clk);
            n++;
            if (req_ready[i]) at = cyc + 1;
        end
        if (at < 0) check($sformatf("accept%0d", i), 0, 1);
        @(posedge clk);
        #2 req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int a0, a1, n, bad;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_id", int'(out_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #2;

        issue(0, 3, 4, 5, LAT, 1);
        wait_acc(0, a0, n);
        drain();
        issue(1, 10, 10, 14, LAT, 1);
        wait_acc(1, a0, n);
        issue(1, 0, 0, 0, LAT, 1);
        wait_acc(1, a0, n);
        issue(0, 255, 255, BIG_R, LAT, 1);
        wait_acc(0, a0, n);
        drain();

        // Reset in the middle of the square root: no result may emerge.
        issue(0, 200, 100, 0, 0, 0);
        wait_acc(0, a0, n);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        check("mid_rst_out_id", int'(out_id), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #2;

        // Simultaneous requests right after reset: requester 0 first.
        issue(0, 6, 8, 10, LAT, 1);
        issue(1, 12, 16, 20, LAT, 1);
        wait_acc(0, a0, n);
        wait_acc(1, a1, n);
        check("rr_gap", a1 - a0, LAT + 2);
        drain();

        // Back-pressure in DONE.
        out_ready = 1'b0;
        issue(1, 10, 10, 14, LAT, 1);
        wait_acc(1, a0, n);
        for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        issue(0, 0, 0, 0, LAT, 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_data != 9'd14 || !out_id || req_ready != 2'b00) bad++;
        end
        check("hold_stable", bad, 0);
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        wait_acc(0, a0, n);
        check("idle_after_pulse", n, 1);
        out_ready = 1'b1;
        drain();

        // Enable dropped for 5 cycles while in SQ_Y.
        issue(0, 3, 4, 5, LAT + 5, 1);
        wait_acc(0, a0, n);
        @(posedge clk);
        #2 ena = 1'b0;
        repeat (5) @(posedge clk);
        #2 ena = 1'b1;
        drain();

        repeat (30) @(negedge clk);
        check("queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
